// File: rtl/regfile_pkg.sv
// Shared types for the register write-back path: register file geometry and queue entry format.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Sync FIFO of write-back entries: up to two pushes (a older than b) and one pop per cycle, plus flush.
// Latency: a push is visible at the head on the cycle after its edge; no bypass from push to head.
// Backpressure: none internally; the caller must never push beyond DEPTH-level free slots.
// Ports: clk/rst (sync, active-high), flush, push_a/din_a, push_b/din_b, pop, head (oldest entry),
//        level (occupancy), ent_vld/ent_dat (entries in age order, index 0 = oldest).
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_a,
  input  wb_entry_t                  din_a,
  input  logic                       push_b,
  input  wb_entry_t                  din_b,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DEPTH-1:0]           ent_vld,
  output wb_entry_t                  ent_dat [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      // Pushes and the pop in a flush cycle are discarded along with the contents.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_a) mem_d[wr_ptr_q] = din_a;
      // b lands after a when both push; alone it takes a's slot.
      if (push_b) mem_d[PTR_W'(wr_ptr_q + PTR_W'(push_a))] = din_b;
      wr_ptr_d = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push_a) + LVL_W'(push_b) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Age-ordered view so the scoreboard can pick the youngest match by scanning upward.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_dat[k] = mem_q[PTR_W'(rd_ptr_q + PTR_W'(k))];
      ent_vld[k] = (LVL_W'(k) < level_q);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-back initiator: queues mem/ALU results and retires at most one register write per cycle.
// Latency: accepted at edge N -> reg_write_en high after edge N+1; scoreboard is combinational.
// Backpressure: ready from free slots only (>=2 both, 1 mem first, 0 none); dest-0 drops still handshake.
// Ports: clk/rst (sync, active-high), flush, mem_*/alu_* producer handshakes, reg_write_* register file
//        strobe (registered), chk_addr -> chk_busy/chk_data forward query, level occupancy.
module reg_writeback_ctrl #(
  // DATA_W/ADDR_W must agree with regfile_pkg, which sizes the queue entries.
  parameter int DATA_W    = regfile_pkg::DATA_W,
  parameter int ADDR_W    = regfile_pkg::ADDR_W,
  parameter int DEPTH     = 4,
  parameter int DROP_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    mem_valid,
  input  logic [ADDR_W-1:0]       mem_dest,
  input  logic [DATA_W-1:0]       mem_data,
  output logic                    mem_ready,
  input  logic                    alu_valid,
  input  logic [ADDR_W-1:0]       alu_dest,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    alu_ready,
  output logic                    reg_write_en,
  output logic [ADDR_W-1:0]       reg_write_dest,
  output logic [DATA_W-1:0]       reg_write_data,
  input  logic [ADDR_W-1:0]       chk_addr,
  output logic                    chk_busy,
  output logic [DATA_W-1:0]       chk_data,
  output logic [$clog2(DEPTH):0]  level
);

  import regfile_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [LVL_W-1:0]  free;
  logic              mem_drop, alu_drop, mem_push, alu_push;
  logic              push_a, push_b, pop;
  wb_entry_t         din_a, din_b, head;
  logic [DEPTH-1:0]  ent_vld;
  wb_entry_t         ent_dat [DEPTH];

  logic              reg_write_en_q, reg_write_en_d;
  logic [ADDR_W-1:0] reg_write_dest_q, reg_write_dest_d;
  logic [DATA_W-1:0] reg_write_data_q, reg_write_data_d;

  // Accept arbitration: mem has priority for the last free slot.
  always_comb begin
    free      = LVL_W'(DEPTH) - level;
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (!rst) begin
      if (free >= LVL_W'(2)) begin
        mem_ready = 1'b1;
        alu_ready = 1'b1;
      end else if (free == LVL_W'(1)) begin
        mem_ready = 1'b1;
        alu_ready = !mem_valid;
      end
    end

    mem_drop = (DROP_ZERO != 0) && (mem_dest == '0);
    alu_drop = (DROP_ZERO != 0) && (alu_dest == '0);
    mem_push = mem_valid && mem_ready && !mem_drop;
    alu_push = alu_valid && alu_ready && !alu_drop;

    push_a     = mem_push || alu_push;
    push_b     = mem_push && alu_push;
    din_a.dest = mem_push ? mem_dest : alu_dest;
    din_a.data = mem_push ? mem_data : alu_data;
    din_b.dest = alu_dest;
    din_b.data = alu_data;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push_a  (push_a),
    .din_a   (din_a),
    .push_b  (push_b),
    .din_b   (din_b),
    .pop     (pop),
    .head    (head),
    .level   (level),
    .ent_vld (ent_vld),
    .ent_dat (ent_dat)
  );

  // Issue: pop every cycle the queue holds something, unless it is being flushed.
  always_comb begin
    pop              = (level != '0) && !flush;
    reg_write_en_d   = pop;
    reg_write_dest_d = pop ? head.dest : reg_write_dest_q;
    reg_write_data_d = pop ? head.data : reg_write_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_en_q   <= 1'b0;
      reg_write_dest_q <= '0;
      reg_write_data_q <= '0;
    end else begin
      reg_write_en_q   <= reg_write_en_d;
      reg_write_dest_q <= reg_write_dest_d;
      reg_write_data_q <= reg_write_data_d;
    end
  end

  assign reg_write_en   = reg_write_en_q;
  assign reg_write_dest = reg_write_dest_q;
  assign reg_write_data = reg_write_data_q;

  // Scoreboard: the strobe on the bus is the oldest pending write, queue entries get younger
  // with index, so later matches overwrite earlier ones and the youngest wins.
  always_comb begin
    chk_busy = 1'b0;
    chk_data = '0;
    if (!((DROP_ZERO != 0) && (chk_addr == '0))) begin
      if (reg_write_en_q && (reg_write_dest_q == chk_addr)) begin
        chk_busy = 1'b1;
        chk_data = reg_write_data_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (ent_vld[k] && (ent_dat[k].dest == chk_addr)) begin
          chk_busy = 1'b1;
          chk_data = ent_dat[k].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed self-checking bench for reg_writeback_ctrl with a small register-file model on the strobe.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: ready values are checked directly against hand-computed expectations.
module tb_reg_writeback_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       mem_valid = 1'b0;
  logic [3:0] mem_dest = '0;
  logic [7:0] mem_data = '0;
  logic       mem_ready;
  logic       alu_valid = 1'b0;
  logic [3:0] alu_dest = '0;
  logic [7:0] alu_data = '0;
  logic       alu_ready;
  logic       reg_write_en;
  logic [3:0] reg_write_dest;
  logic [7:0] reg_write_data;
  logic [3:0] chk_addr = '0;
  logic       chk_busy;
  logic [7:0] chk_data;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;

  logic [7:0] rf [16];

  reg_writeback_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(4), .DROP_ZERO(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .chk_addr(chk_addr), .chk_busy(chk_busy), .chk_data(chk_data), .level(level)
  );

  always #5 clk = ~clk;

  // Register file model written by the strobe.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    end else if (reg_write_en) begin
      rf[reg_write_dest] <= reg_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic [3:0] d, input logic [7:0] x);
    mem_valid = v; mem_dest = d; mem_data = x;
  endtask

  task automatic set_alu(input logic v, input logic [3:0] d, input logic [7:0] x);
    alu_valid = v; alu_dest = d; alu_data = x;
  endtask

  task automatic out(input string tag, input logic en, input logic [3:0] d, input logic [7:0] x,
                     input logic [2:0] lvl);
    check({tag, "_en"}, reg_write_en, en);
    check({tag, "_dest"}, reg_write_dest, d);
    check({tag, "_data"}, reg_write_data, x);
    check({tag, "_level"}, level, lvl);
  endtask

  initial begin
    // 1. Reset, then a single ALU write.
    step();
    out("rst", 1'b0, 4'h0, 8'h00, 3'd0);
    check("rst_busy", chk_busy, 1'b0);
    check("rst_chk_data", chk_data, 8'h00);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b0);
    rst = 1'b0;
    set_alu(1'b1, 4'd3, 8'h07);
    chk_addr = 4'd3;
    #1;
    check("t1_alu_ready", alu_ready, 1'b1);
    check("t1_mem_ready", mem_ready, 1'b1);
    step();
    set_alu(1'b0, 4'd0, 8'h00);
    #1;
    out("t1_acc", 1'b0, 4'h0, 8'h00, 3'd1);
    check("t1_q_busy", chk_busy, 1'b1);
    check("t1_q_data", chk_data, 8'h07);
    step();
    out("t1_iss", 1'b1, 4'd3, 8'h07, 3'd0);
    check("t1_bus_busy", chk_busy, 1'b1);
    step();
    out("t1_idle", 1'b0, 4'd3, 8'h07, 3'd0);
    check("t1_rf3", rf[3], 8'h07);
    check("t1_done_busy", chk_busy, 1'b0);
    check("t1_done_data", chk_data, 8'h00);

    // 2. Simultaneous mem+alu on an empty queue: mem retires first.
    set_mem(1'b1, 4'd5, 8'h11);
    set_alu(1'b1, 4'd6, 8'h22);
    #1;
    check("t2_mem_ready", mem_ready, 1'b1);
    check("t2_alu_ready", alu_ready, 1'b1);
    step();
    set_mem(1'b0, 4'd0, 8'h00);
    set_alu(1'b0, 4'd0, 8'h00);
    #1;
    out("t2_acc", 1'b0, 4'd3, 8'h07, 3'd2);
    step();
    out("t2_w0", 1'b1, 4'd5, 8'h11, 3'd1);
    step();
    out("t2_w1", 1'b1, 4'd6, 8'h22, 3'd0);
    step();
    check("t2_en_off", reg_write_en, 1'b0);
    check("t2_rf5", rf[5], 8'h11);
    check("t2_rf6", rf[6], 8'h22);

    // 3. Continuous dual pushes: occupancy saturates at 3, mem takes the last slot.
    set_mem(1'b1, 4'd1, 8'h31);
    set_alu(1'b1, 4'd2, 8'h32);
    step();
    out("t3_c0", 1'b0, 4'd6, 8'h22, 3'd2);
    set_mem(1'b1, 4'd1, 8'h33);
    set_alu(1'b1, 4'd2, 8'h34);
    #1;
    check("t3_c1_mem_ready", mem_ready, 1'b1);
    check("t3_c1_alu_ready", alu_ready, 1'b1);
    step();
    out("t3_c1", 1'b1, 4'd1, 8'h31, 3'd3);
    set_mem(1'b1, 4'd1, 8'h35);
    set_alu(1'b1, 4'd2, 8'h36);
    #1;
    check("t3_c2_mem_ready", mem_ready, 1'b1);
    check("t3_c2_alu_ready", alu_ready, 1'b0);
    step();
    out("t3_c2", 1'b1, 4'd2, 8'h32, 3'd3);
    set_mem(1'b0, 4'd0, 8'h00);
    #1;
    check("t3_c3_alu_ready", alu_ready, 1'b1);
    step();
    out("t3_c3", 1'b1, 4'd1, 8'h33, 3'd3);
    set_alu(1'b0, 4'd0, 8'h00);
    step();
    out("t3_d0", 1'b1, 4'd2, 8'h34, 3'd2);
    step();
    out("t3_d1", 1'b1, 4'd1, 8'h35, 3'd1);
    step();
    out("t3_d2", 1'b1, 4'd2, 8'h36, 3'd0);
    step();
    check("t3_en_off", reg_write_en, 1'b0);

    // 4. Two writes to r9: scoreboard forwards the younger one until both retire.
    chk_addr = 4'd9;
    set_mem(1'b1, 4'd9, 8'hA0);
    set_alu(1'b1, 4'd9, 8'hA1);
    step();
    set_mem(1'b0, 4'd0, 8'h00);
    set_alu(1'b0, 4'd0, 8'h00);
    #1;
    check("t4_q_busy", chk_busy, 1'b1);
    check("t4_q_data", chk_data, 8'hA1);
    step();
    out("t4_w0", 1'b1, 4'd9, 8'hA0, 3'd1);
    check("t4_mix_data", chk_data, 8'hA1);
    step();
    out("t4_w1", 1'b1, 4'd9, 8'hA1, 3'd0);
    check("t4_bus_busy", chk_busy, 1'b1);
    check("t4_bus_data", chk_data, 8'hA1);
    step();
    check("t4_done_busy", chk_busy, 1'b0);
    check("t4_done_data", chk_data, 8'h00);

    // 5. Flush with three queued entries and one strobe on the bus.
    chk_addr = 4'd8;
    set_mem(1'b1, 4'd7, 8'h51);
    set_alu(1'b1, 4'd8, 8'h52);
    step();
    set_mem(1'b1, 4'd7, 8'h53);
    set_alu(1'b1, 4'd8, 8'h54);
    step();
    set_mem(1'b0, 4'd0, 8'h00);
    set_alu(1'b1, 4'd10, 8'h5F);
    flush = 1'b1;
    #1;
    out("t5_pre", 1'b1, 4'd7, 8'h51, 3'd3);
    check("t5_pre_data", chk_data, 8'h54);
    check("t5_flush_alu_ready", alu_ready, 1'b1);
    step();
    flush = 1'b0;
    set_alu(1'b0, 4'd0, 8'h00);
    #1;
    out("t5_post", 1'b0, 4'd7, 8'h51, 3'd0);
    check("t5_rf7", rf[7], 8'h51);
    check("t5_busy", chk_busy, 1'b0);
    step();
    out("t5_idle", 1'b0, 4'd7, 8'h51, 3'd0);
    check("t5_rf8", rf[8], 8'h00);
    check("t5_rf10", rf[10], 8'h00);

    // 6. Write to r0 is accepted and dropped.
    chk_addr = 4'd0;
    set_alu(1'b1, 4'd0, 8'hFF);
    #1;
    check("t6_alu_ready", alu_ready, 1'b1);
    step();
    set_alu(1'b0, 4'd0, 8'h00);
    #1;
    out("t6_acc", 1'b0, 4'd7, 8'h51, 3'd0);
    check("t6_busy", chk_busy, 1'b0);
    step();
    check("t6_en_off", reg_write_en, 1'b0);

    // 7. Reset mid-operation loses queued writes.
    set_mem(1'b1, 4'd4, 8'h71);
    set_alu(1'b1, 4'd5, 8'h72);
    step();
    set_mem(1'b0, 4'd0, 8'h00);
    set_alu(1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    #1;
    check("t7_pre_level", level, 3'd2);
    check("t7_rst_mem_ready", mem_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    out("t7_rst", 1'b0, 4'd0, 8'h00, 3'd0);
    step();
    out("t7_after", 1'b0, 4'd0, 8'h00, 3'd0);
    check("t7_rf4", rf[4], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
